// File: rtl/axil_write_ingress_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between an AXI master and the write ingress.
interface axil_write_ingress_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                      s_awvalid;
   logic                      s_awready;
   logic [ADDR_WIDTH-1:0]     s_awaddr;
   logic                      s_wvalid;
   logic                      s_wready;
   logic [DATA_WIDTH-1:0]     s_wdata;
   logic [DATA_WIDTH/8-1:0]   s_wstrb;
   logic                      s_bvalid;
   logic                      s_bready;
   logic [1:0]                s_bresp;

   modport master (
      output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
      input  s_awready, s_wready, s_bvalid, s_bresp
   );

   modport slave (
      input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
      output s_awready, s_wready, s_bvalid, s_bresp
   );

endinterface

// File: rtl/axil_write_ingress.sv
// AXI4-Lite write ingress: pairs one AW and one W beat, pushes {addr, strb, data}
// into the write FIFO, then returns the B response. One write in flight at a time.
// Optional build macro AXIL_ALIGN_CHECK_EN: misaligned addresses get SLVERR and no push.
module axil_write_ingress #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                                          clk,
   input  logic                                          rst,
   axil_write_ingress_if.slave                           s_axil,
   output logic                                          fifo_wr_req,
   input  logic                                          fifo_wr_valid,
   output logic [ADDR_WIDTH+DATA_WIDTH/8+DATA_WIDTH-1:0] fifo_data
);

   localparam int unsigned STRB_W      = DATA_WIDTH / 8;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      PUSH    = 2'd1,
      RESP    = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic                  r_aw_held;
   logic [ADDR_WIDTH-1:0] r_aw_addr;
   logic                  r_w_held;
   logic [DATA_WIDTH-1:0] r_w_data;
   logic [STRB_W-1:0]     r_w_strb;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;

   logic                  w_awready;
   logic                  w_wready;
   logic                  w_aw_fire;
   logic                  w_w_fire;
   logic                  w_misaligned;
   logic                  w_load_resp;
   logic [1:0]            w_resp_code;

   // Readys decode from state and holds; held low for the whole reset assertion.
   assign w_awready = ~rst & (r_state == COLLECT) & ~r_aw_held;
   assign w_wready  = ~rst & (r_state == COLLECT) & ~r_w_held;
   assign w_aw_fire = s_axil.s_awvalid & w_awready;
   assign w_w_fire  = s_axil.s_wvalid  & w_wready;

`ifdef AXIL_ALIGN_CHECK_EN
   localparam int unsigned ALIGN_W = $clog2(STRB_W);
   logic [ALIGN_W-1:0] w_pair_lsb;

   // Low address bits of the pair being completed, whether already held or arriving now.
   assign w_pair_lsb   = r_aw_held ? r_aw_addr[ALIGN_W-1:0] : s_axil.s_awaddr[ALIGN_W-1:0];
   assign w_misaligned = |w_pair_lsb;
`else
   assign w_misaligned = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= COLLECT;
      else     r_state <= w_state_next;
   end

   // Next-state, FIFO request and response-load decode.
   always_comb begin
      w_state_next = r_state;
      fifo_wr_req  = 1'b0;
      w_load_resp  = 1'b0;
      w_resp_code  = RESP_OKAY;
      case (r_state)
         COLLECT: begin
            if ((r_aw_held | w_aw_fire) && (r_w_held | w_w_fire)) begin
               if (w_misaligned) begin
                  w_state_next = RESP;
                  w_load_resp  = 1'b1;
                  w_resp_code  = RESP_SLVERR;
               end else begin
                  w_state_next = PUSH;
               end
            end
         end
         PUSH: begin
            fifo_wr_req = ~rst;
            if (fifo_wr_valid) begin
               w_state_next = RESP;
               w_load_resp  = 1'b1;
               w_resp_code  = RESP_OKAY;
            end
         end
         RESP: begin
            if (s_axil.s_bready) w_state_next = COLLECT;
         end
         default: w_state_next = COLLECT;
      endcase
   end

   // Holding registers: capture each beat once, release both when B completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aw_held <= 1'b0;
         r_aw_addr <= '0;
         r_w_held  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
      end else begin
         if (w_aw_fire) begin
            r_aw_held <= 1'b1;
            r_aw_addr <= s_axil.s_awaddr;
         end
         if (w_w_fire) begin
            r_w_held <= 1'b1;
            r_w_data <= s_axil.s_wdata;
            r_w_strb <= s_axil.s_wstrb;
         end
         if (r_state == RESP && s_axil.s_bready) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
      end
   end

   // Registered B channel: load on entry to RESP, drop on handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_load_resp) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_resp_code;
      end else if (r_state == RESP && s_axil.s_bready) begin
         r_bvalid <= 1'b0;
      end
   end

   assign s_axil.s_awready = w_awready;
   assign s_axil.s_wready  = w_wready;
   assign s_axil.s_bvalid  = r_bvalid;
   assign s_axil.s_bresp   = r_bresp;
   assign fifo_data        = {r_aw_addr, r_w_strb, r_w_data};

endmodule

// File: doc/axil_write_ingress.md
# axil_write_ingress

AXI4-Lite slave write-channel front end that sits directly upstream of the write FIFO. It captures the AW and W beats independently and pairs them into one command. It pushes the packed {address, strobe, data} word into the FIFO through the FIFO's request/accept handshake, then returns the B response. Exactly one write is in flight at a time; FIFO backpressure stalls the AXI channels.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width (≥ 3)
- DATA_WIDTH, 32, AXI data width (8·2^n, ≥ 32)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- s_awvalid  in  1  write-address valid
- s_awready  out  1  write-address ready
- s_awaddr  in  ADDR_WIDTH  write address
- s_wvalid  in  1  write-data valid
- s_wready  out  1  write-data ready
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  DATA_WIDTH/8  byte strobes
- s_bvalid  out  1  response valid
- s_bready  in  1  response ready
- s_bresp  out  2  response code (00 OKAY, 10 SLVERR)
- fifo_wr_req  out  1  push request to FIFO
- fifo_wr_valid  in  1  FIFO accept (= fifo_wr_req & ~full); push occurs on a cycle where it is 1
- fifo_data  out  ADDR_WIDTH+DATA_WIDTH/8+DATA_WIDTH  packed {awaddr, wstrb, wdata}, MSB→LSB

## Operation
- Holding registers: aw_held/aw_addr and w_held/w_data/w_strb, one entry each.
- FSM states: COLLECT, PUSH, RESP. Reset state: COLLECT, holds cleared.
- COLLECT:
  - s_awready = ~aw_held; s_wready = ~w_held.
  - A beat is captured on valid & ready.
  - AW and W may arrive in either order or in the same cycle.
  - When both holds are full, or become full on this edge, go to PUSH.
- PUSH:
  - fifo_wr_req = 1; fifo_data is driven from the holding registers and is stable until accepted.
  - Both readys are 0.
  - On fifo_wr_valid = 1: go to RESP and load bresp = OKAY.
  - If fifo_wr_valid stays 0 (FIFO full), remain in PUSH indefinitely.
- RESP:
  - s_bvalid = 1; both readys are 0.
  - On s_bready: clear both holds, s_bvalid → 0, go to COLLECT.
- fifo_wr_req is 1 only in PUSH, so at most one push per command.
- s_bvalid and s_bresp are registered outputs. s_awready, s_wready and fifo_wr_req are decoded from state and holds, and forced to 0 while rst = 1.
- Reset values: s_bvalid 0, s_bresp 00, fifo_data 0, s_awready/s_wready/fifo_wr_req 0 during reset.
- Reset mid-operation:
  - Held beats and any pending response are discarded.
  - No push is issued for a discarded command.
  - s_bvalid drops immediately (asynchronous).

## Timing
- Best case, with AW and W both handshaken in cycle 0:
  - cycle 1: PUSH, fifo_wr_req = 1, accepted if the FIFO is not full
  - cycle 2: s_bvalid = 1
  - cycle 3: readys return to 1, provided s_bready was 1 in cycle 2
- Throughput: one write per 3 cycles minimum.
- AW and W arriving k cycles apart: PUSH begins the cycle after the later beat.
- Each ready deasserts the cycle after its own beat is captured, so a second AW is never accepted before the first command completes.
- FIFO full for N cycles in PUSH: s_bvalid is delayed by N cycles. Data must not be lost or duplicated.

## Configuration
- AXIL_ALIGN_CHECK_EN:
  - Defined: in COLLECT, a pair whose aw_addr[$clog2(DATA_WIDTH/8)-1:0] ≠ 0 goes directly to RESP with bresp = SLVERR. PUSH is skipped and fifo_wr_req stays 0 for that command.
  - Undefined: the low address bits are passed through unchecked, every command is pushed, and bresp is always OKAY.

## Test plan
- Simultaneous beats: AW 0x10 and W 0xDEADBEEF with strb 0xF in cycle 0, FIFO empty. Required: fifo_wr_req in cycle 1 with fifo_data = {0x10, 0xF, 0xDEADBEEF}; s_bvalid = 1 with OKAY in cycle 2.
- W before AW: W 0x1234 with strb 0x3 in cycle 0, AW 0x20 in cycle 3. Required: s_wready = 0 in cycles 1–3; push in cycle 4 with {0x20, 0x3, 0x1234}.
- FIFO full: fifo_wr_valid held 0 for 5 PUSH cycles, then 1. Required: fifo_data is stable throughout, exactly one push occurs, and s_bvalid rises the cycle after the accept.
- B backpressure: s_bready held 0 for 4 cycles in RESP. Required: s_bvalid is held and s_awready/s_wready stay 0; after bready, the next AW is accepted the following cycle.
- Alignment with AXIL_ALIGN_CHECK_EN defined: AW 0x13 with W 0xA5. Required: no fifo_wr_req, s_bresp = 10. Without the macro, the same stimulus is pushed with OKAY.
- Reset in PUSH: assert rst mid-stall. Required: fifo_wr_req, s_bvalid, s_awready and s_wready are 0 immediately. After release: COLLECT with empty holds, and no stale push occurs.
